tone_monitor: RTL and testbench
===============================

Name: tone_monitor

Overview:
Synthesizable multi-channel tone checker for equalizer/codec output streams. Per channel, it smooths samples with a power-of-two moving average, then detects negative-to-positive zero crossings. At each crossing it measures the period in samples and the peak amplitude and checks both against programmable windows. Error counts and the last measurement go out as status for the BIST/debug register bank; this replaces bench-only frequency/amplitude checks with on-chip hardware.

Parameters:
NCH, 2, number of audio channels (ch0 = left, ch1 = right, ...)
DW, 16, signed sample width
AVG_LOG2, 0, moving-average depth = 2**AVG_LOG2 (range 0..6)
CNT_W, 12, width of period counter and period/limit ports
ERR_W, 8, width of each saturating error counter
SKIP, 1, crossings ignored per channel before measuring starts

Ports:
clk  in  1  system clock
RST_n  in  1  async active-low reset
en  in  1  monitor enable; low = clear all per-channel state except error counters
clr_err  in  1  synchronous clear of all error counters and sticky flags
smp_vld  in  1  one-cycle strobe: new sample set on smp
smp  in  NCH*DW  packed signed samples, ch0 in LSBs
min_period, max_period  in  CNT_W each  legal period window, inclusive
min_ampl, max_ampl  in  DW each  legal peak window, signed, inclusive
meas_vld  out  NCH  one-cycle pulse per channel when a measurement completes
period  out  NCH*CNT_W  last measured period per channel
peak  out  NCH*DW  last measured peak per channel
freq_err_cnt  out  NCH*ERR_W  saturating period-error counts
ampl_err_cnt  out  NCH*ERR_W  saturating amplitude-error counts

Behaviour:
- Reset: every output is 0; history buffers, sums, counters, peaks are 0; state is ARM; crossing count is 0; prev_sign is non-negative.
- Smoother: per-channel shift buffer of 2**AVG_LOG2 entries. On smp_vld: sum <= sum + new - oldest (width DW+AVG_LOG2, signed). avg = sum >>> AVG_LOG2 (arithmetic shift, truncates toward -inf). avg is registered and valid 1 cycle after smp_vld (s_vld). With AVG_LOG2=0, avg = sample delayed 1 cycle.
- Crossing: on s_vld, xing = prev_neg & ~avg[DW-1]. Then prev_neg <= avg[DW-1].
- Per-channel FSM:
  - ARM: on each xing, increment xcnt. When xcnt reaches SKIP, go to MEAS with pcnt=1 and pk=avg.
  - MEAS, s_vld without xing: pcnt <= pcnt+1, saturating at all-ones. pk <= max(pk, avg), signed.
  - MEAS, xing: period <= pcnt; peak <= pk. Pulse meas_vld the next cycle. freq_err_cnt += 1 if pcnt is outside [min_period, max_period]. ampl_err_cnt += 1 if pk is outside [min_ampl, max_ampl]. Both counters saturate at all-ones. Restart with pcnt=1, pk=avg.
- Period definition: pcnt counts smoothed samples from a crossing sample (inclusive) to the next crossing sample (exclusive).
- en low: FSM goes to ARM; xcnt, pcnt, pk, sums, history and prev_neg clear; smp_vld is ignored. period, peak and error counters hold.
- Simultaneous events:
  - clr_err together with an error event: the clear wins, and the counter reads 0.
  - en low together with smp_vld: the sample is dropped.
- Channels are fully independent; they share only the limits and control inputs.
- Limit inputs are sampled at the crossing cycle, so changes mid-period apply to the current measurement.

Optional Feature:
TONE_MON_TIMEOUT_EN:
- When defined, adds output to_flag (NCH, sticky, cleared by clr_err or reset).
- In MEAS, when pcnt reaches max_period+1 with no crossing: freq_err_cnt increments once, to_flag sets, and the FSM returns to ARM with xcnt=SKIP-1. The next crossing therefore re-arms without measuring.
- When not defined: no port, no timeout; pcnt only saturates, and the error is reported at the next crossing.

Test Plan:
- Sine, period 5 samples, amplitude 500, on both channels; limits 3..7 and 375..625; AVG_LOG2=0 -> meas_vld every 5 smp_vld, period=5, peak 475..500, all error counts stay 0 over 30 samples.
- Same sine at amplitude 700 -> ampl_err_cnt increments once per period on both channels; freq_err_cnt stays 0.
- Square wave +/-500, period 10, on ch1 only; ch0 at 5 -> ch1 freq_err_cnt increments per period, ch0 counts stay 0 (channel independence).
- AVG_LOG2=2, step input from 0 to 400 -> avg sequence 100, 200, 300, 400 in consecutive s_vld cycles; step from 0 to -3 -> avg is -1 (floor).
- RST_n or en dropped mid-period, then the sine restarts -> no meas_vld until the second crossing after restart (SKIP=1); error counters survive en low but clear on reset. clr_err in the same cycle as an error -> counter reads 0.
- TONE_MON_TIMEOUT_EN defined, DC input +300 after arming, max_period=7 -> 8 samples after the last crossing, to_flag=1 and freq_err_cnt=1 exactly once.

Source files
------------

// File: rtl/tone_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tone_monitor
// Brief   : Per-channel smoothed zero-crossing period/peak checker with
//           saturating error counters. Define TONE_MON_TIMEOUT_EN to add a
//           sticky per-channel period-timeout flag (to_flag).
// Revision: 1.0 - initial release
// ============================================================================
module tone_monitor #(
  parameter int NCH      = 2,
  parameter int DW       = 16,
  parameter int AVG_LOG2 = 0,
  parameter int CNT_W    = 12,
  parameter int ERR_W    = 8,
  parameter int SKIP     = 1
) (
  input  logic                 clk,
  input  logic                 RST_n,
  input  logic                 en,
  input  logic                 clr_err,
  input  logic                 smp_vld,
  input  logic [NCH*DW-1:0]    smp,
  input  logic [CNT_W-1:0]     min_period,
  input  logic [CNT_W-1:0]     max_period,
  input  logic [DW-1:0]        min_ampl,
  input  logic [DW-1:0]        max_ampl,
  output logic [NCH-1:0]       meas_vld,
  output logic [NCH*CNT_W-1:0] period,
  output logic [NCH*DW-1:0]    peak,
  output logic [NCH*ERR_W-1:0] freq_err_cnt,
  output logic [NCH*ERR_W-1:0] ampl_err_cnt
`ifdef TONE_MON_TIMEOUT_EN
  ,
  output logic [NCH-1:0]       to_flag
`endif
);

  localparam int C_DEPTH = 1 << AVG_LOG2;
  localparam int C_SW    = DW + AVG_LOG2;
  localparam int C_XW    = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
  localparam logic [C_XW-1:0] C_SKIP_M1 = C_XW'(SKIP - 1);

  typedef enum logic [0:0] {
    ST_ARM  = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  // Smoothed sample valid; shared by all channels.
  logic r_s_vld;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) r_s_vld <= 1'b0;
    else        r_s_vld <= smp_vld & en;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [DW-1:0]   r_hist [C_DEPTH];
    logic signed [C_SW-1:0] r_sum;
    logic signed [C_SW-1:0] w_sum_nxt;
    logic signed [DW-1:0]   w_new;
    logic signed [DW-1:0]   w_old;
    logic signed [DW-1:0]   w_avg;
    logic                   r_prev_neg;
    logic                   w_xing;

    state_t                 r_state, w_state_nxt;
    logic [C_XW-1:0]        r_xcnt, w_xcnt_nxt;
    logic [CNT_W-1:0]       r_pcnt, w_pcnt_nxt;
    logic signed [DW-1:0]   r_pk, w_pk_nxt;
    logic                   w_meas, w_ferr, w_aerr;

    logic                   r_meas_vld;
    logic [CNT_W-1:0]       r_period;
    logic signed [DW-1:0]   r_peak;
    logic [ERR_W-1:0]       r_ferr_cnt, r_aerr_cnt;

    assign w_new     = smp[c*DW +: DW];
    assign w_old     = r_hist[C_DEPTH-1];
    assign w_sum_nxt = r_sum + C_SW'(w_new) - C_SW'(w_old);
    // Arithmetic shift floors toward -inf, so -3/4 reads as -1.
    assign w_avg     = DW'(r_sum >>> AVG_LOG2);
    assign w_xing    = r_s_vld & r_prev_neg & ~w_avg[DW-1];

    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
        r_sum      <= '0;
        r_prev_neg <= 1'b0;
        for (int i = 0; i < C_DEPTH; i++) r_hist[i] <= '0;
      end else if (!en) begin
        r_sum      <= '0;
        r_prev_neg <= 1'b0;
        for (int i = 0; i < C_DEPTH; i++) r_hist[i] <= '0;
      end else begin
        if (smp_vld) begin
          r_sum     <= w_sum_nxt;
          r_hist[0] <= w_new;
          for (int i = 1; i < C_DEPTH; i++) r_hist[i] <= r_hist[i-1];
        end
        if (r_s_vld) r_prev_neg <= w_avg[DW-1];
      end
    end

`ifdef TONE_MON_TIMEOUT_EN
    logic w_tout;
    logic r_to;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_xcnt_nxt  = r_xcnt;
      w_pcnt_nxt  = r_pcnt;
      w_pk_nxt    = r_pk;
      w_meas      = 1'b0;
      w_ferr      = 1'b0;
      w_aerr      = 1'b0;
`ifdef TONE_MON_TIMEOUT_EN
      w_tout      = 1'b0;
`endif
      if (r_s_vld) begin
        case (r_state)
          ST_ARM: begin
            if (w_xing) begin
              if (r_xcnt >= C_SKIP_M1) begin
                w_state_nxt = ST_MEAS;
                w_pcnt_nxt  = CNT_W'(1);
                w_pk_nxt    = w_avg;
              end else begin
                w_xcnt_nxt  = r_xcnt + C_XW'(1);
              end
            end
          end
          ST_MEAS: begin
            if (w_xing) begin
              w_meas     = 1'b1;
              w_ferr     = (r_pcnt < min_period) || (r_pcnt > max_period);
              w_aerr     = (r_pk < $signed(min_ampl)) || (r_pk > $signed(max_ampl));
              w_pcnt_nxt = CNT_W'(1);
              w_pk_nxt   = w_avg;
            end else begin
              if (r_pcnt != '1) w_pcnt_nxt = r_pcnt + CNT_W'(1);
              if (w_avg > r_pk) w_pk_nxt = w_avg;
`ifdef TONE_MON_TIMEOUT_EN
              // An all-ones limit can never be exceeded by the saturating count.
              if ((r_pcnt >= max_period) && (max_period != '1)) begin
                w_tout      = 1'b1;
                w_ferr      = 1'b1;
                w_state_nxt = ST_ARM;
                w_xcnt_nxt  = C_SKIP_M1;
              end
`endif
            end
          end
          default: w_state_nxt = ST_ARM;
        endcase
      end
    end

    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
        r_state <= ST_ARM;
        r_xcnt  <= '0;
        r_pcnt  <= '0;
        r_pk    <= '0;
      end else if (!en) begin
        r_state <= ST_ARM;
        r_xcnt  <= '0;
        r_pcnt  <= '0;
        r_pk    <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_xcnt  <= w_xcnt_nxt;
        r_pcnt  <= w_pcnt_nxt;
        r_pk    <= w_pk_nxt;
      end
    end

    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
        r_meas_vld <= 1'b0;
        r_period   <= '0;
        r_peak     <= '0;
        r_ferr_cnt <= '0;
        r_aerr_cnt <= '0;
`ifdef TONE_MON_TIMEOUT_EN
        r_to       <= 1'b0;
`endif
      end else begin
        r_meas_vld <= en & w_meas;
        if (en && w_meas) begin
          r_period <= r_pcnt;
          r_peak   <= r_pk;
        end
        // A clear coinciding with an error event leaves the counter at zero.
        if (clr_err) begin
          r_ferr_cnt <= '0;
          r_aerr_cnt <= '0;
`ifdef TONE_MON_TIMEOUT_EN
          r_to       <= 1'b0;
`endif
        end else if (en) begin
          if (w_ferr && (r_ferr_cnt != '1)) r_ferr_cnt <= r_ferr_cnt + ERR_W'(1);
          if (w_aerr && (r_aerr_cnt != '1)) r_aerr_cnt <= r_aerr_cnt + ERR_W'(1);
`ifdef TONE_MON_TIMEOUT_EN
          if (w_tout) r_to <= 1'b1;
`endif
        end
      end
    end

    assign meas_vld[c]                    = r_meas_vld;
    assign period[c*CNT_W +: CNT_W]       = r_period;
    assign peak[c*DW +: DW]               = r_peak;
    assign freq_err_cnt[c*ERR_W +: ERR_W] = r_ferr_cnt;
    assign ampl_err_cnt[c*ERR_W +: ERR_W] = r_aerr_cnt;
`ifdef TONE_MON_TIMEOUT_EN
    assign to_flag[c]                     = r_to;
`endif
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_tone_monitor.sv
`default_nettype none
// Bench for tone_monitor: instances with AVG_LOG2=0 and AVG_LOG2=2 are checked
// every sample against a sample-stream reference model.
module tb_tone_monitor;
  localparam int NCH   = 2;
  localparam int DW    = 16;
  localparam int CNT_W = 12;
  localparam int ERR_W = 8;
  localparam int SKIP  = 1;
  localparam int NI    = 2;
  localparam int PMAX  = (1 << CNT_W) - 1;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic RST_n = 1'b0;
  logic en = 1'b1;
  logic clr_err = 1'b0;
  logic smp_vld = 1'b0;
  logic [NCH*DW-1:0] smp = '0;
  logic [CNT_W-1:0]  min_period = CNT_W'(3);
  logic [CNT_W-1:0]  max_period = CNT_W'(7);
  logic [DW-1:0]     min_ampl = DW'(375);
  logic [DW-1:0]     max_ampl = DW'(625);

  logic [NCH-1:0]       mv  [NI];
  logic [NCH*CNT_W-1:0] per [NI];
  logic [NCH*DW-1:0]    pk  [NI];
  logic [NCH*ERR_W-1:0] fe  [NI];
  logic [NCH*ERR_W-1:0] ae  [NI];
`ifdef TONE_MON_TIMEOUT_EN
  logic [NCH-1:0]       tf  [NI];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tone_monitor #(.NCH(NCH), .DW(DW), .AVG_LOG2(0), .CNT_W(CNT_W), .ERR_W(ERR_W), .SKIP(SKIP)) u_dut0 (
    .clk(clk), .RST_n(RST_n), .en(en), .clr_err(clr_err), .smp_vld(smp_vld), .smp(smp),
    .min_period(min_period), .max_period(max_period), .min_ampl(min_ampl), .max_ampl(max_ampl),
    .meas_vld(mv[0]), .period(per[0]), .peak(pk[0]), .freq_err_cnt(fe[0]), .ampl_err_cnt(ae[0])
`ifdef TONE_MON_TIMEOUT_EN
    , .to_flag(tf[0])
`endif
  );

  tone_monitor #(.NCH(NCH), .DW(DW), .AVG_LOG2(2), .CNT_W(CNT_W), .ERR_W(ERR_W), .SKIP(SKIP)) u_dut2 (
    .clk(clk), .RST_n(RST_n), .en(en), .clr_err(clr_err), .smp_vld(smp_vld), .smp(smp),
    .min_period(min_period), .max_period(max_period), .min_ampl(min_ampl), .max_ampl(max_ampl),
    .meas_vld(mv[1]), .period(per[1]), .peak(pk[1]), .freq_err_cnt(fe[1]), .ampl_err_cnt(ae[1])
`ifdef TONE_MON_TIMEOUT_EN
    , .to_flag(tf[1])
`endif
  );

  // ---------------- reference model ----------------
  int m_hist   [NI][NCH][4];
  bit m_prev_neg [NI][NCH];
  bit m_run    [NI][NCH];
  bit m_mv     [NI][NCH];
  bit m_to     [NI][NCH];
  int m_xcnt   [NI][NCH];
  int m_pcnt   [NI][NCH];
  int m_pk     [NI][NCH];
  int m_period [NI][NCH];
  int m_peak   [NI][NCH];
  int m_ferr   [NI][NCH];
  int m_aerr   [NI][NCH];

  function automatic int avgl(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int sine(input int amp, input int n);
    int t[5] = '{0, 951, 588, -588, -951};
    return amp * t[n % 5] / 1000;
  endfunction

  function automatic logic [NCH*DW-1:0] pack2(input int x0, input int x1);
    logic [NCH*DW-1:0] v;
    v[DW-1:0]    = x0[DW-1:0];
    v[2*DW-1:DW] = x1[DW-1:0];
    return v;
  endfunction

  task automatic model_clear(input int k, input int c);
    for (int i = 0; i < 4; i++) m_hist[k][c][i] = 0;
    m_prev_neg[k][c] = 1'b0;
    m_run[k][c]      = 1'b0;
    m_mv[k][c]       = 1'b0;
    m_xcnt[k][c]     = 0;
    m_pcnt[k][c]     = 0;
    m_pk[k][c]       = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < NCH; c++) begin
        model_clear(k, c);
        m_period[k][c] = 0;
        m_peak[k][c]   = 0;
        m_ferr[k][c]   = 0;
        m_aerr[k][c]   = 0;
        m_to[k][c]     = 1'b0;
      end
  endtask

  task automatic model_sample(input int k, input int c, input int x, input bit clr);
    int d, s, a, minp, maxp, mina, maxa;
    bit xing;
    d = 1 << avgl(k);
    for (int i = d - 1; i > 0; i--) m_hist[k][c][i] = m_hist[k][c][i-1];
    m_hist[k][c][0] = x;
    s = 0;
    for (int i = 0; i < d; i++) s += m_hist[k][c][i];
    a    = floor_div(s, d);
    minp = int'(min_period);
    maxp = int'(max_period);
    mina = int'($signed(min_ampl));
    maxa = int'($signed(max_ampl));
    xing = m_prev_neg[k][c] && (a >= 0);
    m_prev_neg[k][c] = (a < 0);
    m_mv[k][c] = 1'b0;
    if (!m_run[k][c]) begin
      if (xing) begin
        m_xcnt[k][c]++;
        if (m_xcnt[k][c] >= SKIP) begin
          m_run[k][c]  = 1'b1;
          m_pcnt[k][c] = 1;
          m_pk[k][c]   = a;
        end
      end
    end else if (xing) begin
      m_mv[k][c]     = 1'b1;
      m_period[k][c] = m_pcnt[k][c];
      m_peak[k][c]   = m_pk[k][c];
      if (m_pcnt[k][c] < minp || m_pcnt[k][c] > maxp)
        m_ferr[k][c] = (m_ferr[k][c] < EMAX) ? m_ferr[k][c] + 1 : EMAX;
      if (m_pk[k][c] < mina || m_pk[k][c] > maxa)
        m_aerr[k][c] = (m_aerr[k][c] < EMAX) ? m_aerr[k][c] + 1 : EMAX;
      m_pcnt[k][c] = 1;
      m_pk[k][c]   = a;
    end else begin
`ifdef TONE_MON_TIMEOUT_EN
      if (maxp < PMAX && m_pcnt[k][c] + 1 > maxp) begin
        m_ferr[k][c] = (m_ferr[k][c] < EMAX) ? m_ferr[k][c] + 1 : EMAX;
        m_to[k][c]   = 1'b1;
        m_run[k][c]  = 1'b0;
        m_xcnt[k][c] = SKIP - 1;
      end else begin
`endif
        m_pcnt[k][c] = (m_pcnt[k][c] < PMAX) ? m_pcnt[k][c] + 1 : PMAX;
        if (a > m_pk[k][c]) m_pk[k][c] = a;
`ifdef TONE_MON_TIMEOUT_EN
      end
`endif
    end
    if (clr) begin
      m_ferr[k][c] = 0;
      m_aerr[k][c] = 0;
      m_to[k][c]   = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("%s i%0d c%0d meas_vld", tag, k, c), int'(mv[k][c]), int'(m_mv[k][c]));
        check($sformatf("%s i%0d c%0d period", tag, k, c), int'(per[k][c*CNT_W +: CNT_W]), m_period[k][c]);
        check($sformatf("%s i%0d c%0d peak", tag, k, c), int'($signed(pk[k][c*DW +: DW])), m_peak[k][c]);
        check($sformatf("%s i%0d c%0d freq_err", tag, k, c), int'(fe[k][c*ERR_W +: ERR_W]), m_ferr[k][c]);
        check($sformatf("%s i%0d c%0d ampl_err", tag, k, c), int'(ae[k][c*ERR_W +: ERR_W]), m_aerr[k][c]);
`ifdef TONE_MON_TIMEOUT_EN
        check($sformatf("%s i%0d c%0d to_flag", tag, k, c), int'(tf[k][c]), int'(m_to[k][c]));
`endif
      end
  endtask

  // One sample: strobe, then clr_err (if asked) lands on the crossing-evaluation cycle.
  task automatic do_sample(input logic [NCH*DW-1:0] v, input bit clr, input string tag);
    @(negedge clk);
    smp     = v;
    smp_vld = 1'b1;
    @(negedge clk);
    smp_vld = 1'b0;
    clr_err = clr;
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("%s i%0d c%0d meas_vld early", tag, k, c), int'(mv[k][c]), 0);
        if (en) begin
          model_sample(k, c, int'($signed(v[c*DW +: DW])), clr);
        end else begin
          m_mv[k][c] = 1'b0;
          if (clr) begin
            m_ferr[k][c] = 0;
            m_aerr[k][c] = 0;
            m_to[k][c]   = 1'b0;
          end
        end
      end
    @(negedge clk);
    clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic en_drop(input int n);
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < NCH; c++) model_clear(k, c);
    for (int i = 0; i < n; i++)
      do_sample(pack2(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000), 1'b0, "en_low");
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST_n = 1'b0;
    #2;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    RST_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[NCH];
    int a[NCH];
    int ph[NCH];
    int x[NCH];
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    RST_n = 1'b1;

    // Nominal sine, then over-amplitude sine.
    for (int n = 0; n < 30; n++) do_sample(pack2(sine(500, n), sine(500, n)), 1'b0, "sine500");
    for (int n = 0; n < 30; n++) do_sample(pack2(sine(700, n), sine(700, n)), 1'b0, "sine700");
    // clr_err on crossing samples must win over the coincident error.
    for (int n = 0; n < 30; n++)
      do_sample(pack2(sine(700, n), sine(700, n)), (n % 5 == 0) && (n >= 10) && (n < 20), "clr_xing");

    // ch1 square period 10 (out of window), ch0 flat.
    for (int n = 0; n < 40; n++) do_sample(pack2(5, ((n % 10) < 5) ? 500 : -500), 1'b0, "square");

    // Period-2 tone on ch0 drives its freq error counter into saturation.
    for (int n = 0; n < 600; n++) do_sample(pack2((n % 2 == 0) ? -500 : 500, sine(500, n)), 1'b0, "sat");

    // en dropped mid-period, then restart.
    for (int n = 0; n < 7; n++) do_sample(pack2(sine(500, n), sine(500, n)), 1'b0, "pre_en");
    en_drop(3);
    for (int n = 0; n < 30; n++) do_sample(pack2(sine(500, n), sine(500, n)), 1'b0, "post_en");

    // Reset mid-period, then restart.
    for (int n = 0; n < 7; n++) do_sample(pack2(sine(700, n), sine(700, n)), 1'b0, "pre_rst");
    do_reset();
    for (int n = 0; n < 30; n++) do_sample(pack2(sine(500, n), sine(500, n)), 1'b0, "post_rst");

    // Long DC after arming: period counter saturates (or times out).
    do_sample(pack2(-300, -300), 1'b0, "dc");
    for (int n = 0; n < 4100; n++) do_sample(pack2(300, 300), 1'b0, "dc");
    do_sample(pack2(-300, -300), 1'b0, "dc");
    do_sample(pack2(300, 300), 1'b0, "dc");
    do_sample(pack2(-300, -300), 1'b0, "dc");
    do_sample(pack2(300, 300), 1'b0, "dc");

    // Randomized square tones with noise, limits placed around the true values.
    for (int seg = 0; seg < 10; seg++) begin
      for (int c = 0; c < NCH; c++) begin
        p[c]  = int'($urandom_range(4, 16));
        a[c]  = int'($urandom_range(100, 900));
        ph[c] = int'($urandom_range(0, 15));
      end
      min_period = CNT_W'(p[0] - 1 + int'($urandom_range(0, 2)));
      max_period = CNT_W'(p[0] - 1 + int'($urandom_range(0, 2)));
      min_ampl   = DW'(a[0] - 150 + int'($urandom_range(0, 100)));
      max_ampl   = DW'(a[0] - 30 + int'($urandom_range(0, 60)));
      if (seg == 5) do_reset();
      for (int n = 0; n < 40; n++) begin
        for (int c = 0; c < NCH; c++)
          x[c] = ((((n + ph[c]) % p[c]) < p[c] / 2) ? a[c] : -a[c]) + int'($urandom_range(0, 60)) - 30;
        do_sample(pack2(x[0], x[1]), $urandom_range(0, 19) == 0, "random");
        if ($urandom_range(0, 79) == 0) en_drop(int'($urandom_range(1, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
